// File: rtl/ext_beat_ctrl.sv
// EXT-side beat controller: TX FIFO -> AXI W bursts with wlast, AXI R -> RX FIFO.
// Optional rlast/count consistency check enabled by defining EXT_BEAT_CTRL_LAST_CHECK_EN.

module ext_beat_ctrl_cmd_q #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push, pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // NOTE: storage has no reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

module ext_beat_ctrl #(
  parameter int BEAT_CNT_WIDTH  = 8,
  parameter int CMD_QUEUE_DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_burst_req_i,
  output logic                      wr_burst_gnt_o,
  input  logic [BEAT_CNT_WIDTH-1:0] wr_burst_len_i,
  input  logic                      rd_burst_req_i,
  output logic                      rd_burst_gnt_o,
  input  logic [BEAT_CNT_WIDTH-1:0] rd_burst_len_i,
  input  logic [63:0]               tx_data_pop_dat_i,
  input  logic [7:0]                tx_data_pop_strb_i,
  input  logic                      tx_data_pop_gnt_i,
  output logic                      tx_data_pop_req_o,
  output logic [63:0]               axi_w_data_o,
  output logic [7:0]                axi_w_strb_o,
  output logic                      axi_w_last_o,
  output logic                      axi_w_valid_o,
  input  logic                      axi_w_ready_i,
  input  logic [63:0]               axi_r_data_i,
  input  logic                      axi_r_last_i,
  input  logic                      axi_r_valid_i,
  output logic                      axi_r_ready_o,
  output logic [63:0]               rx_data_push_dat_o,
  output logic                      rx_data_push_req_o,
  input  logic                      rx_data_push_gnt_i,
  output logic                      rd_last_err_o,
  output logic                      idle_o
);
  typedef enum logic {W_IDLE, W_BURST}  w_state_e;
  typedef enum logic {R_IDLE, R_ACTIVE} r_state_e;

  logic [BEAT_CNT_WIDTH-1:0] wq_len, rq_len;
  logic                      wq_full, wq_empty, rq_full, rq_empty;
  logic                      wq_pop, rq_pop;

  w_state_e                  w_state_q;
  logic [BEAT_CNT_WIDTH-1:0] w_cnt_q;
  logic [63:0]               w_data_q;
  logic [7:0]                w_strb_q;
  logic                      w_last_q, w_valid_q;
  logic                      load;

  r_state_e                  r_state_q;
  logic [BEAT_CNT_WIDTH-1:0] r_cnt_q;
  logic                      r_active, r_hs;

  ext_beat_ctrl_cmd_q #(.WIDTH(BEAT_CNT_WIDTH), .DEPTH(CMD_QUEUE_DEPTH)) u_wr_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (wr_burst_req_i),
    .data_i  (wr_burst_len_i),
    .pop_i   (wq_pop),
    .data_o  (wq_len),
    .full_o  (wq_full),
    .empty_o (wq_empty)
  );

  ext_beat_ctrl_cmd_q #(.WIDTH(BEAT_CNT_WIDTH), .DEPTH(CMD_QUEUE_DEPTH)) u_rd_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rd_burst_req_i),
    .data_i  (rd_burst_len_i),
    .pop_i   (rq_pop),
    .data_o  (rq_len),
    .full_o  (rq_full),
    .empty_o (rq_empty)
  );

  assign wr_burst_gnt_o = ~wq_full;
  assign rd_burst_gnt_o = ~rq_full;

  // Write side: the W register refills whenever it is empty or being accepted.
  assign wq_pop            = (w_state_q == W_IDLE) & ~wq_empty;
  assign load              = (w_state_q == W_BURST) & (~w_valid_q | axi_w_ready_i) & tx_data_pop_gnt_i;
  assign tx_data_pop_req_o = load;
  assign axi_w_data_o      = w_data_q;
  assign axi_w_strb_o      = w_strb_q;
  assign axi_w_last_o      = w_last_q;
  assign axi_w_valid_o     = w_valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_last_q  <= 1'b0;
      w_valid_q <= 1'b0;
    end else begin
      if (load) begin
        w_data_q  <= tx_data_pop_dat_i;
        w_strb_q  <= tx_data_pop_strb_i;
        w_last_q  <= (w_cnt_q == '0);
        w_valid_q <= 1'b1;
      end else if (axi_w_ready_i) begin
        w_valid_q <= 1'b0;
      end
      case (w_state_q)
        W_IDLE: begin
          if (!wq_empty) begin
            w_cnt_q   <= wq_len;
            w_state_q <= W_BURST;
          end
        end
        W_BURST: begin
          if (load) begin
            if (w_cnt_q == '0) w_state_q <= W_IDLE;
            else               w_cnt_q   <= w_cnt_q - 1'b1;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Read side: combinational pass-through while a burst is active.
  assign r_active           = (r_state_q == R_ACTIVE);
  assign rq_pop             = ~r_active & ~rq_empty;
  assign axi_r_ready_o      = r_active & rx_data_push_gnt_i;
  assign rx_data_push_req_o = r_active & axi_r_valid_i;
  assign rx_data_push_dat_o = r_active ? axi_r_data_i : '0;
  assign r_hs               = r_active & axi_r_valid_i & rx_data_push_gnt_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (!rq_empty) begin
            r_cnt_q   <= rq_len;
            r_state_q <= R_ACTIVE;
          end
        end
        R_ACTIVE: begin
          if (r_hs) begin
            if (r_cnt_q == '0) r_state_q <= R_IDLE;
            else               r_cnt_q   <= r_cnt_q - 1'b1;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

`ifdef EXT_BEAT_CTRL_LAST_CHECK_EN
  logic rd_last_err_q;

  // Sticky: the burst still terminates on the count, rlast is only audited.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                          rd_last_err_q <= 1'b0;
    else if (r_hs && (axi_r_last_i != (r_cnt_q == '0)))   rd_last_err_q <= 1'b1;
  end
  assign rd_last_err_o = rd_last_err_q;
`else
  logic unused_r_last;
  assign unused_r_last = axi_r_last_i;
  assign rd_last_err_o = 1'b0;
`endif

  assign idle_o = wq_empty & rq_empty & (w_state_q == W_IDLE) & (r_state_q == R_IDLE) & ~w_valid_q;
endmodule

// File: tb/tb_ext_beat_ctrl.sv
// Scoreboard bench for ext_beat_ctrl: expected W/RX beats are queued with the stimulus
// and compared as the DUT hands them over.

module tb_ext_beat_ctrl;
  localparam int BW = 8;
`ifdef EXT_BEAT_CTRL_LAST_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct { logic [63:0] data; logic [7:0] strb; logic last; } w_beat_t;
  typedef struct { logic [63:0] data; logic last; } r_beat_t;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          wr_burst_req_i, rd_burst_req_i;
  logic          wr_burst_gnt_o, rd_burst_gnt_o;
  logic [BW-1:0] wr_burst_len_i, rd_burst_len_i;
  logic [63:0]   tx_data_pop_dat_i;
  logic [7:0]    tx_data_pop_strb_i;
  logic          tx_data_pop_gnt_i, tx_data_pop_req_o;
  logic [63:0]   axi_w_data_o;
  logic [7:0]    axi_w_strb_o;
  logic          axi_w_last_o, axi_w_valid_o, axi_w_ready_i;
  logic [63:0]   axi_r_data_i;
  logic          axi_r_last_i, axi_r_valid_i, axi_r_ready_o;
  logic [63:0]   rx_data_push_dat_o;
  logic          rx_data_push_req_o, rx_data_push_gnt_i;
  logic          rd_last_err_o, idle_o;

  ext_beat_ctrl #(.BEAT_CNT_WIDTH(BW), .CMD_QUEUE_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .wr_burst_req_i(wr_burst_req_i), .wr_burst_gnt_o(wr_burst_gnt_o), .wr_burst_len_i(wr_burst_len_i),
    .rd_burst_req_i(rd_burst_req_i), .rd_burst_gnt_o(rd_burst_gnt_o), .rd_burst_len_i(rd_burst_len_i),
    .tx_data_pop_dat_i(tx_data_pop_dat_i), .tx_data_pop_strb_i(tx_data_pop_strb_i),
    .tx_data_pop_gnt_i(tx_data_pop_gnt_i), .tx_data_pop_req_o(tx_data_pop_req_o),
    .axi_w_data_o(axi_w_data_o), .axi_w_strb_o(axi_w_strb_o), .axi_w_last_o(axi_w_last_o),
    .axi_w_valid_o(axi_w_valid_o), .axi_w_ready_i(axi_w_ready_i),
    .axi_r_data_i(axi_r_data_i), .axi_r_last_i(axi_r_last_i), .axi_r_valid_i(axi_r_valid_i),
    .axi_r_ready_o(axi_r_ready_o),
    .rx_data_push_dat_o(rx_data_push_dat_o), .rx_data_push_req_o(rx_data_push_req_o),
    .rx_data_push_gnt_i(rx_data_push_gnt_i),
    .rd_last_err_o(rd_last_err_o), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  w_beat_t     tx_q[$], exp_w[$];
  r_beat_t     r_q[$];
  logic [63:0] exp_r[$];
  logic        tx_en, tx_popped, r_hs_s, wr_gnt_s, rd_gnt_s;
  int          total = 0, bad = 0, cyc = 0;
  int          tx_pops = 0, w_hs_cnt = 0, r_hs_cnt = 0;
  int          w_first_cyc, w_last_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic update_srcs();
    tx_data_pop_gnt_i  = tx_en && (tx_q.size() > 0);
    tx_data_pop_dat_i  = (tx_q.size() > 0) ? tx_q[0].data : '0;
    tx_data_pop_strb_i = (tx_q.size() > 0) ? tx_q[0].strb : '0;
    axi_r_valid_i      = (r_q.size() > 0);
    axi_r_data_i       = (r_q.size() > 0) ? r_q[0].data : '0;
    axi_r_last_i       = (r_q.size() > 0) ? r_q[0].last : 1'b0;
  endtask

  // Negedge: sample and score; posedge+1: retire consumed source words.
  task automatic tick();
    w_beat_t e;
    @(negedge clk);
    tx_popped = tx_data_pop_req_o;
    wr_gnt_s  = wr_burst_gnt_o;
    rd_gnt_s  = rd_burst_gnt_o;
    r_hs_s    = axi_r_valid_i & axi_r_ready_o;
    if (tx_popped) tx_pops++;
    if (axi_w_valid_o && axi_w_ready_i) begin
      if (exp_w.size() == 0) check("w_unexpected", 1, 0);
      else begin
        e = exp_w.pop_front();
        check("w_data", axi_w_data_o, e.data);
        check("w_strb", axi_w_strb_o, e.strb);
        check("w_last", axi_w_last_o, e.last);
      end
      if (w_hs_cnt == 0 || w_first_cyc < 0) w_first_cyc = cyc;
      w_last_cyc = cyc;
      w_hs_cnt++;
    end
    if (rx_data_push_req_o && rx_data_push_gnt_i) begin
      if (exp_r.size() == 0) check("r_unexpected", 1, 0);
      else check("rx_data", rx_data_push_dat_o, exp_r.pop_front());
      r_hs_cnt++;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (tx_popped && tx_q.size() > 0) void'(tx_q.pop_front());
    if (r_hs_s && r_q.size() > 0) void'(r_q.pop_front());
    update_srcs();
  endtask

  task automatic add_wr_burst(input int len, input int seed);
    w_beat_t b;
    for (int i = 0; i <= len; i++) begin
      b.data = (64'(seed) << 32) | 64'(i * 17 + 3);
      b.strb = 8'(seed * 5 + i);
      b.last = (i == len);
      tx_q.push_back(b);
      exp_w.push_back(b);
    end
    update_srcs();
  endtask

  task automatic add_rd_burst(input int len, input int seed, input int last_at);
    r_beat_t b;
    for (int i = 0; i <= len; i++) begin
      b.data = (64'(seed) << 40) ^ 64'(i * 29 + 1);
      b.last = (i == last_at);
      r_q.push_back(b);
      exp_r.push_back(b.data);
    end
    update_srcs();
  endtask

  task automatic wr_cmd(input int len, output int k);
    int n;
    wr_burst_req_i = 1'b1;
    wr_burst_len_i = BW'(len);
    for (n = 0; n < 20; n++) begin
      tick();
      if (wr_gnt_s) break;
    end
    if (n == 20) check("wr_cmd_timeout", 0, 1);
    k = cyc;
    wr_burst_req_i = 1'b0;
  endtask

  task automatic rd_cmd(input int len, output int k);
    int n;
    rd_burst_req_i = 1'b1;
    rd_burst_len_i = BW'(len);
    for (n = 0; n < 20; n++) begin
      tick();
      if (rd_gnt_s) break;
    end
    if (n == 20) check("rd_cmd_timeout", 0, 1);
    k = cyc;
    rd_burst_req_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    for (n = 0; n < 300; n++) begin
      if (idle_o && exp_w.size() == 0 && exp_r.size() == 0) break;
      tick();
    end
    check(tag, (idle_o && exp_w.size() == 0 && exp_r.size() == 0), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pop_req"}, tx_data_pop_req_o, 0);
    check({tag, "_w_data"},  axi_w_data_o, 0);
    check({tag, "_w_strb"},  axi_w_strb_o, 0);
    check({tag, "_w_last"},  axi_w_last_o, 0);
    check({tag, "_w_valid"}, axi_w_valid_o, 0);
    check({tag, "_r_ready"}, axi_r_ready_o, 0);
    check({tag, "_rx_req"},  rx_data_push_req_o, 0);
    check({tag, "_rx_dat"},  rx_data_push_dat_o, 0);
    check({tag, "_err"},     rd_last_err_o, 0);
    check({tag, "_wr_gnt"},  wr_burst_gnt_o, 1);
    check({tag, "_rd_gnt"},  rd_burst_gnt_o, 1);
    check({tag, "_idle"},    idle_o, 1);
  endtask

  initial begin
    int k, base, pops0, n;
    logic [63:0] d0;
    logic [7:0]  s0;
    logic        l0, tog;

    rst_ni = 1'b0;
    wr_burst_req_i = 1'b0; rd_burst_req_i = 1'b0;
    wr_burst_len_i = '0;   rd_burst_len_i = '0;
    tx_en = 1'b1; axi_w_ready_i = 1'b1; rx_data_push_gnt_i = 1'b1;
    w_first_cyc = -1; w_last_cyc = -1;
    update_srcs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_ni = 1'b1;
    tick();

    // Single write burst: 4 back-to-back beats from edge k+2.
    add_wr_burst(3, 1);
    base = w_hs_cnt; pops0 = tx_pops; w_first_cyc = -1;
    wr_cmd(3, k);
    for (n = 0; n < 30 && (w_hs_cnt - base) < 4; n++) tick();
    check("t1_beats", w_hs_cnt - base, 4);
    check("t1_first_cyc", w_first_cyc, k + 2);
    check("t1_last_cyc", w_last_cyc, k + 5);
    check("t1_pops", tx_pops - pops0, 4);
    wait_idle("t1_idle");

    // W backpressure on beat 0.
    axi_w_ready_i = 1'b0;
    add_wr_burst(1, 2);
    wr_cmd(1, k);
    for (n = 0; n < 10 && !axi_w_valid_o; n++) tick();
    check("t2_valid", axi_w_valid_o, 1);
    d0 = axi_w_data_o; s0 = axi_w_strb_o; l0 = axi_w_last_o;
    check("t2_beat0_data", d0, exp_w[0].data);
    pops0 = tx_pops;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_hold_data", axi_w_data_o, d0);
      check("t2_hold_strb", axi_w_strb_o, s0);
      check("t2_hold_last", axi_w_last_o, l0);
      check("t2_hold_valid", axi_w_valid_o, 1);
    end
    check("t2_no_pop", tx_pops - pops0, 0);
    axi_w_ready_i = 1'b1;
    wait_idle("t2_idle");

    // Queue full: FSM stalled on a burst with no TX data.
    tx_en = 1'b0;
    add_wr_burst(0, 3);
    wr_cmd(0, k);
    repeat (2) tick();
    add_wr_burst(1, 4);
    add_wr_burst(2, 5);
    add_wr_burst(0, 6);
    wr_burst_req_i = 1'b1;
    wr_burst_len_i = 8'd1;
    tick();
    check("t3_push1", wr_gnt_s, 1);
    wr_burst_len_i = 8'd2;
    tick();
    check("t3_push2", wr_gnt_s, 1);
    wr_burst_len_i = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_full_gnt", wr_gnt_s, 0);
    end
    check("t3_not_idle", idle_o, 0);
    tx_en = 1'b1;
    update_srcs();
    for (n = 0; n < 30; n++) begin
      tick();
      if (wr_gnt_s) break;
    end
    check("t3_third_accepted", wr_gnt_s, 1);
    wr_burst_req_i = 1'b0;
    wait_idle("t3_idle");

    // Read burst len=7 with RX backpressure toggling.
    add_rd_burst(7, 7, 7);
    base = r_hs_cnt;
    rd_cmd(7, k);
    tog = 1'b1;
    for (n = 0; n < 60 && (r_hs_cnt - base) < 8; n++) begin
      rx_data_push_gnt_i = tog;
      tog = ~tog;
      #1;
      if (cyc >= k + 1) begin
        check("t4_ready_mirror", axi_r_ready_o, rx_data_push_gnt_i);
        check("t4_push_req", rx_data_push_req_o, axi_r_valid_i);
      end
      tick();
    end
    check("t4_beats", r_hs_cnt - base, 8);
    rx_data_push_gnt_i = 1'b1;
    add_rd_burst(0, 9, 0);
    void'(exp_r.pop_back());
    #1;
    check("t4_idle_ready", axi_r_ready_o, 0);
    check("t4_idle_req", rx_data_push_req_o, 0);
    repeat (3) tick();
    check("t4_no_extra", r_hs_cnt - base, 8);
    r_q.delete();
    update_srcs();

    // rlast on beat 2 of a len=3 read.
    check("t5_err_before", rd_last_err_o, 0);
    add_rd_burst(3, 11, 2);
    base = r_hs_cnt;
    rd_cmd(3, k);
    for (n = 0; n < 30 && (r_hs_cnt - base) < 4; n++) tick();
    check("t5_beats", r_hs_cnt - base, 4);
    check("t5_err", rd_last_err_o, EXP_ERR);
    repeat (3) tick();
    check("t5_err_sticky", rd_last_err_o, EXP_ERR);
    check("t5_ended_ready", axi_r_ready_o, 0);
    check("t5_no_extra", r_hs_cnt - base, 4);
    wait_idle("t5_idle");

    // Reset during beat 2 of a len=5 write.
    add_wr_burst(5, 12);
    base = w_hs_cnt;
    wr_cmd(5, k);
    for (n = 0; n < 30 && (w_hs_cnt - base) < 2; n++) tick();
    check("t6_at_beat2", axi_w_valid_o, 1);
    rst_ni = 1'b0;
    tx_q.delete();
    exp_w.delete();
    #1;
    check_reset_outputs("t6_rst");
    update_srcs();
    tick();
    rst_ni = 1'b1;
    #1;
    check("t6_idle_after", idle_o, 1);
    tick();
    check("t6_err_cleared", rd_last_err_o, 0);
    add_wr_burst(0, 13);
    wr_cmd(0, k);
    wait_idle("t6_recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
